sdp_mrdma_eg_rsp_rcv: RTL and testbench

Read-response receiver for the SDP MRDMA path. It sits opposite the ingress read-request pipe: it accepts DMA read-return beats from the memory interface and buffers them in order. It hands the beats to the SDP egress datapath through a registered valid/ready output stage. It also owns the request credit, so ingress never has more requests outstanding than the block can absorb.

---
 rtl/sdp_mrdma_eg_rsp_rcv.sv | 140 ++++++++++++++
 tb/tb_sdp_mrdma_eg_rsp_rcv.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/sdp_mrdma_eg_rsp_rcv.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : sdp_mrdma_eg_rsp_rcv
// Description : MRDMA read-response receiver. It keeps beats in order through
//               a FIFO and a registered output stage, and owns the request credit.
// Revision    : 1.0 - initial release
// ============================================================================
module sdp_mrdma_eg_rsp_rcv #(
  parameter int DW = 514,
  parameter int AW = 3
) (
  input  logic          nvdla_core_clk,
  input  logic          nvdla_core_rstn,
  input  logic          ig_req_accept,
  output logic          ig_req_credit,
  input  logic          dma_rd_rsp_vld,
  output logic          dma_rd_rsp_rdy,
  input  logic [DW-1:0] dma_rd_rsp_pd,
  output logic          eg_rsp_valid,
  input  logic          eg_rsp_ready,
  output logic [DW-1:0] eg_rsp_pd,
  output logic [AW:0]   reserved_cnt,
  output logic [AW:0]   inflight_cnt,
  output logic          proto_err
);

  localparam int          DEPTH       = 1 << AW;
  localparam logic [AW:0] c_depth_cnt = (AW+1)'(DEPTH);
  localparam logic [AW:0] c_one       = (AW+1)'(1);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic          valid_q, valid_d;
  logic [DW-1:0] pd_q;
  logic [AW:0]   res_q, res_d;
  logic [AW:0]   infl_q, infl_d;
  logic          err_q, err_d;

  logic w_fifo_empty;
  logic w_fifo_full;
  logic w_acc_in;
  logic w_out_fire;
  logic w_load_en;
  logic w_fifo_rd;
  logic w_bypass;
  logic w_fifo_wr;
  logic w_err_req;
  logic w_err_rsp;

  assign w_fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign w_fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign dma_rd_rsp_rdy = !w_fifo_full;
  assign w_acc_in       = dma_rd_rsp_vld && !w_fifo_full;
  assign w_out_fire     = valid_q && eg_rsp_ready;

  // The output register takes a new beat whenever it is empty or draining;
  // the FIFO head always wins over the incoming beat to keep arrival order.
  assign w_load_en = !valid_q || w_out_fire;
  assign w_fifo_rd = w_load_en && !w_fifo_empty;
  assign w_bypass  = w_load_en && w_fifo_empty && w_acc_in;
  assign w_fifo_wr = w_acc_in && !w_bypass;

  assign w_err_req = ig_req_accept && !w_out_fire && (res_q == c_depth_cnt);
  assign w_err_rsp = w_acc_in && !ig_req_accept && (infl_q == '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    valid_d  = valid_q;
    if (w_fifo_wr) wr_ptr_d = wr_ptr_q + c_one;
    if (w_fifo_rd) rd_ptr_d = rd_ptr_q + c_one;
    if (w_load_en) valid_d = w_fifo_rd || w_bypass;
  end

  always_comb begin
    res_d = res_q;
    if (ig_req_accept && !w_out_fire) begin
      if (res_q != c_depth_cnt) res_d = res_q + c_one;
    end else if (!ig_req_accept && w_out_fire) begin
      if (res_q != '0) res_d = res_q - c_one;
    end
  end

  always_comb begin
    infl_d = infl_q;
    if (ig_req_accept && !w_acc_in) begin
      infl_d = infl_q + c_one;
    end else if (!ig_req_accept && w_acc_in) begin
      if (infl_q != '0) infl_d = infl_q - c_one;
    end
  end

  always_comb begin
    err_d = err_q || w_err_req || w_err_rsp;
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      valid_q  <= 1'b0;
      res_q    <= '0;
      infl_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      valid_q  <= valid_d;
      res_q    <= res_d;
      infl_q   <= infl_d;
      err_q    <= err_d;
    end
  end

  // Payload storage carries no reset.
  always_ff @(posedge nvdla_core_clk) begin
    if (w_fifo_wr) mem_q[wr_ptr_q[AW-1:0]] <= dma_rd_rsp_pd;
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (w_fifo_rd) begin
      pd_q <= mem_q[rd_ptr_q[AW-1:0]];
    end else if (w_bypass) begin
      pd_q <= dma_rd_rsp_pd;
    end
  end

  assign ig_req_credit = (res_q < c_depth_cnt);
  assign eg_rsp_valid  = valid_q;
  assign eg_rsp_pd     = pd_q;
  assign reserved_cnt  = res_q;
  assign inflight_cnt  = infl_q;
  assign proto_err     = err_q;

endmodule
`default_nettype wire

// File: tb/tb_sdp_mrdma_eg_rsp_rcv.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_sdp_mrdma_eg_rsp_rcv
// Description : Directed vector table plus ordered random-stall scoreboard run.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sdp_mrdma_eg_rsp_rcv;

  localparam int DW = 514;
  localparam int AW = 3;

  typedef struct {
    logic        acc;
    logic        vld;
    logic [15:0] pd;
    logic        rdy;
    logic        e_val;
    logic [15:0] e_pd;
    int          e_res;
    int          e_infl;
    logic        e_cred;
    logic        e_err;
  } vec_t;

  logic          clk;
  logic          rst_n;
  logic          ig_req_accept;
  logic          ig_req_credit;
  logic          dma_rd_rsp_vld;
  logic          dma_rd_rsp_rdy;
  logic [DW-1:0] dma_rd_rsp_pd;
  logic          eg_rsp_valid;
  logic          eg_rsp_ready;
  logic [DW-1:0] eg_rsp_pd;
  logic [AW:0]   reserved_cnt;
  logic [AW:0]   inflight_cnt;
  logic          proto_err;

  int checks;
  int errors;

  sdp_mrdma_eg_rsp_rcv #(.DW(DW), .AW(AW)) u_dut (
    .nvdla_core_clk  (clk),
    .nvdla_core_rstn (rst_n),
    .ig_req_accept   (ig_req_accept),
    .ig_req_credit   (ig_req_credit),
    .dma_rd_rsp_vld  (dma_rd_rsp_vld),
    .dma_rd_rsp_rdy  (dma_rd_rsp_rdy),
    .dma_rd_rsp_pd   (dma_rd_rsp_pd),
    .eg_rsp_valid    (eg_rsp_valid),
    .eg_rsp_ready    (eg_rsp_ready),
    .eg_rsp_pd       (eg_rsp_pd),
    .reserved_cnt    (reserved_cnt),
    .inflight_cnt    (inflight_cnt),
    .proto_err       (proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] widen(input logic [15:0] p);
    return DW'({33{p}});
  endfunction

  function automatic logic [DW-1:0] rand_pd();
    logic [DW-1:0] d;
    d = '0;
    for (int w = 0; w < 17; w++) d = {d[DW-33:0], 32'($urandom)};
    return d;
  endfunction

  function automatic vec_t mk(input logic a, input logic v, input logic [15:0] p,
                              input logic r, input logic ev, input logic [15:0] ep,
                              input int er, input int ei, input logic ec, input logic ee);
    vec_t t;
    t.acc = a; t.vld = v; t.pd = p; t.rdy = r;
    t.e_val = ev; t.e_pd = ep; t.e_res = er; t.e_infl = ei; t.e_cred = ec; t.e_err = ee;
    return t;
  endfunction

  task automatic idle_inputs();
    ig_req_accept  = 1'b0;
    dma_rd_rsp_vld = 1'b0;
    dma_rd_rsp_pd  = '0;
    eg_rsp_ready   = 1'b0;
  endtask

  task automatic chk_state(input string tag, input logic ev, input int er, input int ei,
                           input logic ec, input logic ee);
    chk({tag, "_valid"},  DW'(eg_rsp_valid),   DW'(ev));
    chk({tag, "_res"},    DW'(reserved_cnt),   DW'(er));
    chk({tag, "_infl"},   DW'(inflight_cnt),   DW'(ei));
    chk({tag, "_credit"}, DW'(ig_req_credit),  DW'(ec));
    chk({tag, "_rdy"},    DW'(dma_rd_rsp_rdy), DW'(1'b1));
    chk({tag, "_err"},    DW'(proto_err),      DW'(ee));
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    ig_req_accept  = v.acc;
    dma_rd_rsp_vld = v.vld;
    dma_rd_rsp_pd  = widen(v.pd);
    eg_rsp_ready   = v.rdy;
    @(posedge clk); #1;
    chk_state(tag, v.e_val, v.e_res, v.e_infl, v.e_cred, v.e_err);
    if (v.e_val) chk({tag, "_pd"}, eg_rsp_pd, widen(v.e_pd));
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk_state("rst", 1'b0, 0, 0, 1'b1, 1'b0);
    @(posedge clk); #1;
    chk_state("rst_idle", 1'b0, 0, 0, 1'b1, 1'b0);
  endtask

  vec_t          vt[$];
  logic [DW-1:0] q[$];
  logic [DW-1:0] last_pd;
  logic [DW-1:0] exp_pd;
  logic          stalled;
  logic          acc, vld, rdy, fire;
  int            res_m, infl_m, issued, got;

  initial begin
    checks = 0;
    errors = 0;
    idle_inputs();
    rst_n = 1'b0;

    // single request / single beat with empty-block latency
    vt.push_back(mk(0, 0, 16'h0,   1, 0, 16'h0,   0, 0, 1, 0));
    vt.push_back(mk(1, 0, 16'h0,   1, 0, 16'h0,   1, 1, 1, 0));
    vt.push_back(mk(0, 0, 16'h0,   1, 0, 16'h0,   1, 1, 1, 0));
    vt.push_back(mk(0, 1, 16'h155, 1, 1, 16'h155, 1, 0, 1, 0));
    vt.push_back(mk(0, 0, 16'h0,   1, 0, 16'h0,   0, 0, 1, 0));
    // fill to credit limit, buffer 8 beats, drain in order
    for (int i = 1; i <= 8; i++) vt.push_back(mk(1, 0, 16'h0, 0, 0, 16'h0, i, i, i < 8, 0));
    for (int i = 1; i <= 8; i++) vt.push_back(mk(0, 1, 16'(i), 0, 1, 16'h1, 8, 8 - i, 0, 0));
    for (int k = 1; k <= 8; k++) vt.push_back(mk(0, 0, 16'h0, 1, k < 8, 16'(k + 1), 8 - k, 0, 1, 0));
    // same-cycle accept+drain at the limit, then a lone over-limit accept
    for (int i = 1; i <= 8; i++) vt.push_back(mk(1, 0, 16'h0, 0, 0, 16'h0, i, i, i < 8, 0));
    vt.push_back(mk(0, 1, 16'h2A, 0, 1, 16'h2A, 8, 7, 0, 0));
    vt.push_back(mk(1, 0, 16'h0,  1, 0, 16'h0,  8, 8, 0, 0));
    vt.push_back(mk(1, 0, 16'h0,  0, 0, 16'h0,  8, 9, 0, 1));

    do_reset();
    foreach (vt[i]) run_vec($sformatf("v%0d", i), vt[i]);

    // unsolicited beat: no underflow, still delivered
    do_reset();
    run_vec("unsol0", mk(0, 1, 16'h3C3, 1, 1, 16'h3C3, 0, 0, 1, 1));
    run_vec("unsol1", mk(0, 0, 16'h0,   1, 0, 16'h0,   0, 0, 1, 1));

    // random stalls with a credit-honouring source
    do_reset();
    res_m = 0; infl_m = 0; issued = 0; got = 0; stalled = 1'b0; last_pd = '0;
    for (int cyc = 0; cyc < 20000 && got < 1000; cyc++) begin
      acc  = (issued < 1000) && (res_m < 8) && ($urandom_range(0, 1) == 1);
      vld  = (infl_m > 0) && ($urandom_range(0, 3) != 0);
      rdy  = ($urandom_range(0, 1) == 1);
      ig_req_accept  = acc;
      dma_rd_rsp_vld = vld;
      dma_rd_rsp_pd  = vld ? rand_pd() : '0;
      eg_rsp_ready   = rdy;
      fire = eg_rsp_valid && rdy;
      if (stalled) begin
        chk("stall_valid", DW'(eg_rsp_valid), DW'(1'b1));
        chk("stall_pd", eg_rsp_pd, last_pd);
      end
      if (fire) begin
        if (q.size() == 0) begin
          chk("extra_beat", DW'(1'b1), DW'(1'b0));
        end else begin
          exp_pd = q.pop_front();
          chk("order_pd", eg_rsp_pd, exp_pd);
        end
      end
      if (vld) q.push_back(dma_rd_rsp_pd);
      stalled = eg_rsp_valid && !rdy;
      last_pd = eg_rsp_pd;
      res_m  = res_m + int'(acc) - int'(fire);
      infl_m = infl_m + int'(acc) - int'(vld);
      issued = issued + int'(acc);
      got    = got + int'(fire);
      @(posedge clk); #1;
      chk("rand_res",  DW'(reserved_cnt),   DW'(res_m));
      chk("rand_infl", DW'(inflight_cnt),   DW'(infl_m));
      chk("rand_rdy",  DW'(dma_rd_rsp_rdy), DW'(1'b1));
    end
    chk("rand_delivered", DW'(got), DW'(1000));
    chk("rand_err", DW'(proto_err), DW'(1'b0));

    // asynchronous reset with one beat in the output stage and 4 in the FIFO
    idle_inputs();
    ig_req_accept = 1'b1;
    repeat (5) @(posedge clk);
    #1 ig_req_accept = 1'b0;
    dma_rd_rsp_vld = 1'b1;
    for (int i = 0; i < 5; i++) begin
      dma_rd_rsp_pd = widen(16'(16'hA0 + i));
      @(posedge clk); #1;
    end
    dma_rd_rsp_vld = 1'b0;
    chk("pre_rst_valid", DW'(eg_rsp_valid), DW'(1'b1));
    chk("pre_rst_res", DW'(reserved_cnt), DW'(5));
    #3 rst_n = 1'b0;
    #1;
    chk_state("async_rst", 1'b0, 0, 0, 1'b1, 1'b0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk_state("post_rst", 1'b0, 0, 0, 1'b1, 1'b0);
    run_vec("late0", mk(0, 1, 16'hBEEF, 1, 1, 16'hBEEF, 0, 0, 1, 1));
    run_vec("late1", mk(0, 0, 16'h0,    1, 0, 16'h0,    0, 0, 1, 1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
